// File: rtl/commit_trace_tx_pkg.sv
// commit_trace_tx_pkg: record layout, header bit positions and serializer states for the commit trace link
package commit_trace_tx_pkg;
    localparam int SEQ_W = 8;
    localparam int HDR_HALT = 15;
    localparam int HDR_REG_WR = 14;
    localparam int HDR_MEM_RD = 13;
    localparam int HDR_MEM_WR = 12;
    localparam int HDR_LOST = 11;
    localparam int HDR_REG = 8;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PC, S_REGD, S_ADDR, S_MDATA, S_DONE} state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] wr_data;
        logic [15:0] addr;
        logic [15:0] mem_data;
        logic halt;
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
        logic [2:0] wr_reg;
        logic lost;
        logic [SEQ_W-1:0] seq;
    } rec_t;

    function automatic logic [15:0] header(input rec_t r);
        logic [15:0] h;
        h = '0;
        h[HDR_HALT] = r.halt;
        h[HDR_REG_WR] = r.reg_wr;
        h[HDR_MEM_RD] = r.mem_rd;
        h[HDR_MEM_WR] = r.mem_wr;
        h[HDR_LOST] = r.lost;
        h[HDR_REG +: 3] = r.wr_reg;
        h[SEQ_W-1:0] = r.seq;
        return h;
    endfunction

    // S_IDLE doubles as "no further field": the current word is the record's last
    function automatic state_t next_field(input state_t s, input rec_t r);
        return s == S_HDR ? S_PC :
               s == S_PC && r.reg_wr ? S_REGD :
               (s == S_PC || s == S_REGD) && (r.mem_rd || r.mem_wr) ? S_ADDR :
               s == S_ADDR && r.mem_wr ? S_MDATA : S_IDLE;
    endfunction

    function automatic logic [15:0] word_of(input state_t s, input rec_t r);
        return s == S_HDR ? header(r) :
               s == S_PC ? r.pc :
               s == S_REGD ? r.wr_data :
               s == S_ADDR ? r.addr : r.mem_data;
    endfunction
endpackage

// File: rtl/commit_trace_tx_fifo.sv
// commit_trace_tx_fifo: synchronous record FIFO with registered occupancy and a header view of the second entry
module commit_trace_tx_fifo
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  rec_t        din,
    output rec_t        head,
    output logic [15:0] peek_hdr,
    output logic        full,
    output logic        empty,
    output logic        multi
);
    localparam int AW = $clog2(DEPTH);

    rec_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [AW:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            rd <= rd + AW'(pop);
            wr <= wr + AW'(push);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end

    assign head = mem[rd];
    assign peek_hdr = header(mem[rd + AW'(1)]);
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign multi = count > (AW+1)'(1);
endmodule

// File: rtl/commit_trace_tx.sv
// commit_trace_tx: captures retiring instructions into a record FIFO and serializes them as 16-bit trace words
module commit_trace_tx
    import commit_trace_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        commit_valid,
    input  logic [15:0] commit_pc,
    input  logic        commit_reg_wr,
    input  logic [2:0]  commit_wr_reg,
    input  logic [15:0] commit_wr_data,
    input  logic        commit_mem_rd,
    input  logic        commit_mem_wr,
    input  logic [15:0] commit_mem_addr,
    input  logic [15:0] commit_mem_data,
    input  logic        commit_halt,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_data,
    output logic        tx_last,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        done
);
    state_t state, nxt;
    rec_t cur_rec, pend_rec, rec_in, head;
    logic [15:0] peek_hdr;
    logic [SEQ_W-1:0] seq;
    logic halted, halt_pend, lost_pend, sample, push, hs, fin, full, empty, multi;

    always_comb begin
        cur_rec = '{pc: commit_pc, wr_data: commit_wr_data, addr: commit_mem_addr,
                    mem_data: commit_mem_data, halt: commit_halt, reg_wr: commit_reg_wr,
                    mem_rd: commit_mem_rd, mem_wr: commit_mem_wr, wr_reg: commit_wr_reg,
                    lost: 1'b0, seq: seq};
        rec_in = halt_pend ? pend_rec : cur_rec;
        rec_in.lost = lost_pend;
    end

    assign sample = commit_valid & ~halted;
    assign push = (halt_pend | sample) & ~full;
    assign hs = tx_valid & tx_ready;
    assign nxt = next_field(state, head);
    assign fin = hs && nxt == S_IDLE;

    commit_trace_tx_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(fin), .din(rec_in),
        .head(head), .peek_hdr(peek_hdr), .full(full), .empty(empty), .multi(multi)
    );

    // a halt arriving while full waits in pend_rec instead of being dropped
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq <= '0;
            halted <= 1'b0;
            halt_pend <= 1'b0;
            lost_pend <= 1'b0;
            overflow <= 1'b0;
            drop_count <= '0;
            pend_rec <= '0;
        end else begin
            if (sample) seq <= seq + SEQ_W'(1);
            if (sample && commit_halt) halted <= 1'b1;
            if (sample && full && commit_halt) begin
                halt_pend <= 1'b1;
                pend_rec <= cur_rec;
            end else if (sample && full) begin
                overflow <= 1'b1;
                drop_count <= drop_count + 16'(drop_count != 16'hFFFF);
                lost_pend <= 1'b1;
            end
            if (push) begin
                halt_pend <= 1'b0;
                lost_pend <= 1'b0;
            end
        end
    end

    // the record stays in the FIFO until its last word leaves, so back-to-back headers come from peek_hdr
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data <= '0;
            tx_last <= 1'b0;
            done <= 1'b0;
        end else if (state == S_IDLE && !empty) begin
            state <= S_HDR;
            tx_valid <= 1'b1;
            tx_data <= header(head);
            tx_last <= 1'b0;
        end else if (hs && !fin) begin
            state <= nxt;
            tx_data <= word_of(nxt, head);
            tx_last <= next_field(nxt, head) == S_IDLE;
        end else if (fin) begin
            state <= head.halt ? S_DONE : multi ? S_HDR : S_IDLE;
            tx_valid <= !head.halt && multi;
            tx_data <= !head.halt && multi ? peek_hdr : '0;
            tx_last <= 1'b0;
            done <= head.halt;
        end
    end
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed and randomized checks of the commit trace transmitter against a word-queue model
module tb_commit_trace_tx;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n, commit_valid, commit_reg_wr, commit_mem_rd, commit_mem_wr, commit_halt, tx_ready;
    logic [15:0] commit_pc, commit_wr_data, commit_mem_addr, commit_mem_data;
    logic [2:0] commit_wr_reg;
    logic tx_valid, tx_last, overflow, done;
    logic [15:0] tx_data, drop_count;

    always #5 clk = ~clk;

    commit_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .commit_reg_wr(commit_reg_wr), .commit_wr_reg(commit_wr_reg), .commit_wr_data(commit_wr_data),
        .commit_mem_rd(commit_mem_rd), .commit_mem_wr(commit_mem_wr), .commit_mem_addr(commit_mem_addr),
        .commit_mem_data(commit_mem_data), .commit_halt(commit_halt), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last), .overflow(overflow),
        .drop_count(drop_count), .done(done)
    );

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct { logic [15:0] d; bit last; bit halt; int pedge; } word_t;
    typedef struct { logic [15:0] pc, wd, addr, md; bit halt, rw, rd, wr; logic [2:0] r; logic [7:0] seq; } cmt_t;

    word_t q[$];
    int nrec = 0, edge_n = 0;
    bit m_halted, m_hpend, m_lost, m_ovf, m_done, m_valid, chk_on;
    logic [15:0] m_drop;
    logic [7:0] m_seq;
    cmt_t m_hrec;

    // a record becomes a list of words; its header may appear no sooner than the edge after its push
    task automatic enqueue(input cmt_t c, input bit lost);
        word_t w;
        w.halt = c.halt;
        w.pedge = edge_n;
        w.d = (16'(c.halt) << 15) | (16'(c.rw) << 14) | (16'(c.rd) << 13) | (16'(c.wr) << 12)
            | (16'(lost) << 11) | (16'(c.r) << 8) | 16'(c.seq);
        w.last = 0;
        q.push_back(w);
        w.d = c.pc; w.last = !(c.rw || c.rd || c.wr);
        q.push_back(w);
        if (c.rw) begin w.d = c.wd; w.last = !(c.rd || c.wr); q.push_back(w); end
        if (c.rd || c.wr) begin w.d = c.addr; w.last = !c.wr; q.push_back(w); end
        if (c.wr) begin w.d = c.md; w.last = 1; q.push_back(w); end
        nrec++;
    endtask

    initial forever begin
        cmt_t c;
        word_t w;
        bit hs;
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            q.delete();
            nrec = 0;
            {m_halted, m_hpend, m_lost, m_ovf, m_done} = '0;
            m_drop = 0;
            m_seq = 0;
        end else begin
            hs = m_valid && tx_ready;
            c.pc = commit_pc; c.wd = commit_wr_data; c.addr = commit_mem_addr; c.md = commit_mem_data;
            c.halt = commit_halt; c.rw = commit_reg_wr; c.rd = commit_mem_rd; c.wr = commit_mem_wr;
            c.r = commit_wr_reg; c.seq = m_seq;
            if (m_hpend && nrec < DEPTH) begin
                enqueue(m_hrec, m_lost);
                m_lost = 0;
                m_hpend = 0;
            end else if (commit_valid && !m_halted) begin
                m_seq++;
                m_halted = commit_halt;
                if (nrec < DEPTH) begin
                    enqueue(c, m_lost);
                    m_lost = 0;
                end else if (commit_halt) begin
                    m_hpend = 1;
                    m_hrec = c;
                end else begin
                    m_ovf = 1;
                    m_lost = 1;
                    if (m_drop != 16'hFFFF) m_drop++;
                end
            end
            if (hs) begin
                w = q.pop_front();
                if (w.last) begin
                    nrec--;
                    if (w.halt) m_done = 1;
                end
            end
        end
        m_valid = !m_done && q.size() > 0 && q[0].pedge < edge_n;
    end

    always @(negedge clk) if (chk_on) begin
        chk("tx_valid", tx_valid, m_valid);
        if (m_valid) begin
            chk("tx_data", tx_data, q[0].d);
            chk("tx_last", tx_last, q[0].last);
        end
        chk("overflow", overflow, m_ovf);
        chk("drop_count", drop_count, m_drop);
        chk("done", done, m_done);
    end

    logic [16:0] log_q[$];
    always @(negedge clk) if (tx_valid && tx_ready) log_q.push_back({tx_last, tx_data});

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic commit(input logic [15:0] pc, input logic rw, input logic [2:0] r, input logic [15:0] wd,
                          input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] md,
                          input logic h);
        commit_valid = 1; commit_pc = pc; commit_reg_wr = rw; commit_wr_reg = r; commit_wr_data = wd;
        commit_mem_rd = rd; commit_mem_wr = wr; commit_mem_addr = a; commit_mem_data = md; commit_halt = h;
        step();
        commit_valid = 0;
    endtask

    task automatic plain(input logic [15:0] pc);
        commit(pc, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 0);
    endtask

    task automatic reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic chk_w(input string name, input int i, input logic [16:0] exp);
        chk(name, i < log_q.size() ? 32'(log_q[i]) : 32'hDEAD0000, 32'(exp));
    endtask

    int crate[4] = '{50, 90, 30, 100};
    int rrate[4] = '{50, 30, 90, 100};

    initial begin
        bit found;
        rst_n = 0; tx_ready = 0; commit_valid = 0; commit_pc = 0; commit_reg_wr = 0; commit_wr_reg = 0;
        commit_wr_data = 0; commit_mem_rd = 0; commit_mem_wr = 0; commit_mem_addr = 0; commit_mem_data = 0;
        commit_halt = 0;
        step(2);
        chk_on = 1;
        rst_n = 1;
        chk("reset tx_valid", tx_valid, 0);
        chk("reset overflow", overflow, 0);
        chk("reset drop_count", drop_count, 0);
        chk("reset done", done, 0);

        tx_ready = 1;
        log_q.delete();
        commit(16'h0002, 1, 3'd3, 16'h1234, 0, 0, 16'h0, 16'h0, 0);
        @(negedge clk);
        chk("t1 no word at push edge", tx_valid, 0);
        @(negedge clk);
        chk("t1 header latency", {tx_valid, tx_data}, {1'b1, 16'h4300});
        step(6);
        chk("t1 words", log_q.size(), 3);
        chk_w("t1 hdr", 0, 17'h04300);
        chk_w("t1 pc", 1, 17'h00002);
        chk_w("t1 regd", 2, 17'h11234);

        log_q.delete();
        commit(16'h0010, 0, 3'd0, 16'h0, 0, 1, 16'h0040, 16'hBEEF, 0);
        step(7);
        chk("t2 words", log_q.size(), 4);
        chk_w("t2 hdr", 0, 17'h01001);
        chk_w("t2 pc", 1, 17'h00010);
        chk_w("t2 addr", 2, 17'h00040);
        chk_w("t2 mdata", 3, 17'h1BEEF);

        tx_ready = 0;
        log_q.delete();
        commit(16'h0030, 1, 3'd5, 16'h00AA, 1, 0, 16'h0100, 16'h0, 0);
        for (int i = 0; i < 10 && !tx_valid; i++) step();
        chk("t3 hdr held", tx_data, 16'h6502);
        tx_ready = 1;
        step();
        tx_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3 pc held", {tx_valid, tx_data, tx_last}, {1'b1, 16'h0030, 1'b0});
        end
        tx_ready = 1;
        step(6);
        chk("t3 words", log_q.size(), 4);
        chk_w("t3 hdr", 0, 17'h06502);
        chk_w("t3 pc", 1, 17'h00030);
        chk_w("t3 regd", 2, 17'h000AA);
        chk_w("t3 addr", 3, 17'h10100);

        reset();
        tx_ready = 0;
        log_q.delete();
        for (int i = 0; i < 10; i++) plain(16'h0100 + 16'(i));
        chk("t4 overflow", overflow, 1);
        chk("t4 drop_count", drop_count, 2);
        tx_ready = 1;
        step(24);
        chk("t4 drained", log_q.size(), 16);
        chk_w("t4 hdr7", 14, 17'h00007);
        chk_w("t4 pc7", 15, 17'h10107);
        log_q.delete();
        plain(16'h00AB);
        step(5);
        chk_w("t4 lost hdr", 0, 17'h0080A);
        chk_w("t4 lost pc", 1, 17'h100AB);

        reset();
        tx_ready = 0;
        for (int i = 0; i < 8; i++) plain(16'h0200 + 16'(i));
        commit(16'h0099, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        plain(16'h0300);
        chk("t5 halt not dropped", {overflow, drop_count}, 17'h0);
        log_q.delete();
        tx_ready = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (tx_valid && tx_last && tx_data == 16'h0099) begin
                found = 1;
                chk("t5 done early", done, 0);
                @(negedge clk);
                chk("t5 done", {done, tx_valid}, {1'b1, 1'b0});
            end
        end
        chk("t5 halt seen", found, 1);
        step();
        chk("t5 words", log_q.size(), 18);
        chk_w("t5 halt hdr", 16, 17'h08008);
        chk_w("t5 halt pc", 17, 17'h10099);
        for (int i = 0; i < 5; i++) begin
            plain(16'h0400);
            chk("t5 silent", {tx_valid, done}, {1'b0, 1'b1});
        end

        reset();
        tx_ready = 0;
        for (int i = 0; i < 10; i++) commit(16'h0500 + 16'(i), 1, 3'd2, 16'h1111, 0, 0, 16'h0, 16'h0, 0);
        tx_ready = 1;
        step(4);
        rst_n = 0;
        step();
        chk("t6 reset", {tx_valid, overflow, drop_count, done}, 19'h0);
        rst_n = 1;
        log_q.delete();
        plain(16'h0077);
        step(5);
        chk_w("t6 hdr", 0, 17'h00000);
        chk_w("t6 pc", 1, 17'h10077);

        for (int s = 0; s < 4; s++) begin
            reset();
            for (int c = 0; c < 700; c++) begin
                commit_valid = $urandom_range(99) < crate[s];
                commit_pc = 16'($urandom);
                commit_reg_wr = 1'($urandom);
                commit_wr_reg = 3'($urandom);
                commit_wr_data = 16'($urandom);
                commit_mem_rd = 1'($urandom);
                commit_mem_wr = 1'($urandom);
                commit_mem_addr = 16'($urandom);
                commit_mem_data = 16'($urandom);
                commit_halt = $urandom_range(299) == 0;
                tx_ready = $urandom_range(99) < rrate[s];
                step();
            end
        end
        commit_valid = 0;
        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
